// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the core memory stage and an
// external loader/debug port; core has priority, external gets a bounded burst after MAX_WAIT denials.
module dmem_arbiter #(
    parameter int unsigned AW       = 12,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned BURST    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic [3:0]    c_we,
    input  logic [AW-1:0] c_adr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_stall,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          x_req,
    input  logic [3:0]    x_we,
    input  logic [AW-1:0] x_adr,
    input  logic [DW-1:0] x_wdata,
    output logic          x_gnt,
    output logic          x_rvalid,
    output logic [DW-1:0] x_rdata,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned WW = $clog2(MAX_WAIT + 1);
    localparam int unsigned BW = $clog2(BURST + 1);

    localparam logic [0:0] ST_CORE = 1'b0;
    localparam logic [0:0] ST_EXT  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic          c_rd_q, c_rd_d;
    logic          x_rd_q, x_rd_d;

    logic          core_wins_s;
    logic          c_gnt_s;
    logic          x_gnt_s;
    logic [WW-1:0] wait_inc_s;
    logic [BW-1:0] burst_inc_s;

    assign wait_inc_s  = wait_cnt_q + WW'(1);
    assign burst_inc_s = burst_cnt_q + BW'(1);

    // Winner selection; grants are forced off while reset is held low
    always_comb begin
        core_wins_s = 1'b1;
        case (state_q)
            ST_CORE: core_wins_s = 1'b1;
            ST_EXT:  core_wins_s = ~x_req;
            default: core_wins_s = 1'b1;
        endcase
        c_gnt_s = reset & c_req & core_wins_s;
        x_gnt_s = reset & x_req & ~c_gnt_s;
    end

    // Memory port mux: the winner drives the memory, idle cycles default to core address/data
    always_comb begin
        mem_en    = c_gnt_s | x_gnt_s;
        mem_we    = 4'b0000;
        mem_adr   = c_adr;
        mem_wdata = c_wdata;
        if (x_gnt_s) begin
            mem_we    = x_we;
            mem_adr   = x_adr;
            mem_wdata = x_wdata;
        end else if (c_gnt_s) begin
            mem_we    = c_we;
        end else begin
            mem_we    = 4'b0000;
        end
    end

    // Fairness FSM and its wait/burst counters
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_CORE: begin
                burst_cnt_d = {BW{1'b0}};
                if (x_req & ~x_gnt_s) begin
                    if (wait_inc_s == WW'(MAX_WAIT)) begin
                        state_d    = ST_EXT;
                        wait_cnt_d = {WW{1'b0}};
                    end else begin
                        wait_cnt_d = wait_inc_s;
                    end
                end else begin
                    wait_cnt_d = {WW{1'b0}};
                end
            end
            ST_EXT: begin
                wait_cnt_d = {WW{1'b0}};
                if (!x_req) begin
                    // External side went quiet: hand priority back immediately
                    state_d     = ST_CORE;
                    burst_cnt_d = {BW{1'b0}};
                end else if (x_gnt_s) begin
                    if (burst_inc_s == BW'(BURST)) begin
                        state_d     = ST_CORE;
                        burst_cnt_d = {BW{1'b0}};
                    end else begin
                        burst_cnt_d = burst_inc_s;
                    end
                end else begin
                    burst_cnt_d = burst_cnt_q;
                end
            end
            default: begin
                state_d     = ST_CORE;
                wait_cnt_d  = {WW{1'b0}};
                burst_cnt_d = {BW{1'b0}};
            end
        endcase
    end

    // Read-owner tracking: one bit per port marks a read issued this cycle
    always_comb begin
        c_rd_d = c_gnt_s & (c_we == 4'b0000);
        x_rd_d = x_gnt_s & (x_we == 4'b0000);
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_CORE;
            wait_cnt_q  <= {WW{1'b0}};
            burst_cnt_q <= {BW{1'b0}};
            c_rd_q      <= 1'b0;
            x_rd_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            c_rd_q      <= c_rd_d;
            x_rd_q      <= x_rd_d;
        end
    end

    assign c_stall  = c_req & ~c_gnt_s;
    assign x_gnt    = x_gnt_s;
    assign c_rvalid = c_rd_q;
    assign x_rvalid = x_rd_q;
    assign c_rdata  = mem_rdata;
    assign x_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: default instance plus a MAX_WAIT=1/BURST=2 instance
// sharing the same stimulus.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        c_req, x_req;
    logic [3:0]  c_we, x_we;
    logic [11:0] c_adr, x_adr;
    logic [31:0] c_wdata, x_wdata, mem_rdata;

    logic        c_stall, c_rvalid, x_gnt, x_rvalid, mem_en;
    logic [31:0] c_rdata, x_rdata, mem_wdata;
    logic [3:0]  mem_we;
    logic [11:0] mem_adr;

    logic        c_stall2, c_rvalid2, x_gnt2, x_rvalid2, mem_en2;
    logic [31:0] c_rdata2, x_rdata2, mem_wdata2;
    logic [3:0]  mem_we2;
    logic [11:0] mem_adr2;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata),
        .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .x_req(x_req), .x_we(x_we), .x_adr(x_adr), .x_wdata(x_wdata),
        .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.MAX_WAIT(1), .BURST(2)) dut2 (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata),
        .c_stall(c_stall2), .c_rvalid(c_rvalid2), .c_rdata(c_rdata2),
        .x_req(x_req), .x_we(x_we), .x_adr(x_adr), .x_wdata(x_wdata),
        .x_gnt(x_gnt2), .x_rvalid(x_rvalid2), .x_rdata(x_rdata2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_adr(mem_adr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_c(input logic req, input logic [3:0] we, input logic [11:0] adr,
                           input logic [31:0] wd);
        c_req = req; c_we = we; c_adr = adr; c_wdata = wd;
    endtask

    task automatic drive_x(input logic req, input logic [3:0] we, input logic [11:0] adr,
                           input logic [31:0] wd);
        x_req = req; x_we = we; x_adr = adr; x_wdata = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic ext_e, prev_c, prev_x;

        // Reset held: no memory activity, core stalled if requesting
        reset = 1'b0;
        mem_rdata = 32'h0;
        drive_c(1'b1, 4'b0000, 12'h010, 32'h0);
        drive_x(1'b1, 4'b0000, 12'h020, 32'h0);
        #2;
        chk("rst_c_stall", 32'(c_stall), 32'd1);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_x_gnt", 32'(x_gnt), 32'd0);
        tick();
        chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
        chk("rst_x_rvalid", 32'(x_rvalid), 32'd0);
        drive_c(1'b0, 4'b0000, 12'h000, 32'h0);
        drive_x(1'b0, 4'b0000, 12'h000, 32'h0);
        reset = 1'b1;

        // Core read at 0x010, no external request
        drive_c(1'b1, 4'b0000, 12'h010, 32'h0);
        #2;
        chk("t1_c_stall", 32'(c_stall), 32'd0);
        chk("t1_mem_en", 32'(mem_en), 32'd1);
        chk("t1_mem_adr", 32'(mem_adr), 32'h010);
        chk("t1_mem_we", 32'(mem_we), 32'd0);
        tick();
        drive_c(1'b0, 4'b0000, 12'h000, 32'h0);
        mem_rdata = 32'h1234_5678;
        #2;
        chk("t1_c_rvalid", 32'(c_rvalid), 32'd1);
        chk("t1_c_rdata", c_rdata, 32'h1234_5678);
        chk("t1_x_rvalid", 32'(x_rvalid), 32'd0);
        chk("t1_idle_en", 32'(mem_en), 32'd0);
        tick();

        // Core store racing an external request
        drive_c(1'b1, 4'b0011, 12'h044, 32'hDEAD_BEEF);
        drive_x(1'b1, 4'b0000, 12'h055, 32'h0);
        #2;
        chk("t2_mem_we", 32'(mem_we), 32'h3);
        chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t2_mem_adr", 32'(mem_adr), 32'h044);
        chk("t2_x_gnt", 32'(x_gnt), 32'd0);
        chk("t2_c_stall", 32'(c_stall), 32'd0);
        tick();
        drive_c(1'b0, 4'b0000, 12'h000, 32'h0);
        drive_x(1'b0, 4'b0000, 12'h000, 32'h0);
        #2;
        chk("t2_c_rvalid", 32'(c_rvalid), 32'd0);
        chk("t2_x_rvalid", 32'(x_rvalid), 32'd0);
        tick();

        // Continuous contention: period 8 on default instance, period 3 on the small one
        prev_c = 1'b0;
        prev_x = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_c(1'b1, 4'b0000, 12'h100, 32'h0);
            drive_x(1'b1, 4'b0000, 12'h200, 32'h0);
            #2;
            ext_e = ((i % 8) >= 4);
            chk($sformatf("t3_x_gnt_%0d", i), 32'(x_gnt), 32'(ext_e));
            chk($sformatf("t3_c_stall_%0d", i), 32'(c_stall), 32'(ext_e));
            chk($sformatf("t3_mem_adr_%0d", i), 32'(mem_adr), ext_e ? 32'h200 : 32'h100);
            chk($sformatf("t3_c_rvalid_%0d", i), 32'(c_rvalid), 32'(prev_c));
            chk($sformatf("t3_x_rvalid_%0d", i), 32'(x_rvalid), 32'(prev_x));
            chk($sformatf("t3_mw1_x_gnt_%0d", i), 32'(x_gnt2), 32'((i % 3) != 0));
            prev_c = ~ext_e;
            prev_x = ext_e;
            tick();
        end
        drive_c(1'b0, 4'b0000, 12'h000, 32'h0);
        drive_x(1'b0, 4'b0000, 12'h000, 32'h0);
        #2;
        chk("t3_tail_x_rvalid", 32'(x_rvalid), 32'd1);
        chk("t3_tail_c_rvalid", 32'(c_rvalid), 32'd0);
        tick();

        // External window cut short after two grants
        for (int i = 0; i < 6; i++) begin
            drive_c(1'b1, 4'b1111, 12'h001, 32'h0);
            drive_x(1'b1, 4'b1111, 12'h002, 32'h0);
            #2;
            chk($sformatf("t4_x_gnt_%0d", i), 32'(x_gnt), 32'(i >= 4));
            tick();
        end
        drive_x(1'b0, 4'b0000, 12'h000, 32'h0);
        #2;
        chk("t4_drop_c_stall", 32'(c_stall), 32'd0);
        chk("t4_drop_mem_en", 32'(mem_en), 32'd1);
        chk("t4_drop_x_gnt", 32'(x_gnt), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive_x(1'b1, 4'b1111, 12'h002, 32'h0);
            #2;
            chk($sformatf("t4_refill_x_gnt_%0d", i), 32'(x_gnt), 32'(i == 4));
            tick();
        end
        drive_c(1'b0, 4'b0000, 12'h000, 32'h0);
        drive_x(1'b0, 4'b0000, 12'h000, 32'h0);
        tick();

        // Core idle: external granted every cycle, FSM unaffected
        for (int i = 0; i < 6; i++) begin
            drive_x(1'b1, 4'b1111, 12'h003, 32'h0);
            #2;
            chk($sformatf("t4b_x_gnt_%0d", i), 32'(x_gnt), 32'd1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive_c(1'b1, 4'b1111, 12'h004, 32'h0);
            #2;
            chk($sformatf("t4b_core_wins_%0d", i), 32'(x_gnt), 32'd0);
            tick();
        end
        drive_c(1'b0, 4'b0000, 12'h000, 32'h0);
        drive_x(1'b0, 4'b0000, 12'h000, 32'h0);
        tick();

        // Interleaved reads: core then external
        drive_c(1'b1, 4'b0000, 12'h0A0, 32'h0);
        #2;
        chk("t5_c_gnt", 32'(c_stall), 32'd0);
        tick();
        drive_c(1'b0, 4'b0000, 12'h000, 32'h0);
        drive_x(1'b1, 4'b0000, 12'h0B0, 32'h0);
        mem_rdata = 32'hAAAA_0001;
        #2;
        chk("t5_x_gnt", 32'(x_gnt), 32'd1);
        chk("t5_c_rvalid", 32'(c_rvalid), 32'd1);
        chk("t5_c_rdata", c_rdata, 32'hAAAA_0001);
        chk("t5_x_rvalid_early", 32'(x_rvalid), 32'd0);
        tick();
        drive_x(1'b0, 4'b0000, 12'h000, 32'h0);
        mem_rdata = 32'hBBBB_0002;
        #2;
        chk("t5_x_rvalid", 32'(x_rvalid), 32'd1);
        chk("t5_x_rdata", x_rdata, 32'hBBBB_0002);
        chk("t5_c_rvalid_late", 32'(c_rvalid), 32'd0);
        tick();
        #2;
        chk("t5_quiet_c", 32'(c_rvalid), 32'd0);
        chk("t5_quiet_x", 32'(x_rvalid), 32'd0);
        tick();

        // Reset right after an external read grant in EXT
        for (int i = 0; i < 5; i++) begin
            drive_c(1'b1, 4'b1111, 12'h010, 32'h0);
            drive_x(1'b1, 4'b0000, 12'h020, 32'h0);
            #2;
            chk($sformatf("t6_x_gnt_%0d", i), 32'(x_gnt), 32'(i == 4));
            tick();
        end
        reset = 1'b0;
        #2;
        chk("t6_rst_x_rvalid", 32'(x_rvalid), 32'd0);
        chk("t6_rst_mem_en", 32'(mem_en), 32'd0);
        chk("t6_rst_x_gnt", 32'(x_gnt), 32'd0);
        chk("t6_rst_c_stall", 32'(c_stall), 32'd1);
        tick();
        reset = 1'b1;
        #2;
        chk("t6_post_x_rvalid", 32'(x_rvalid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                #2;
            end
            chk($sformatf("t6_post_x_gnt_%0d", i), 32'(x_gnt), 32'(i == 4));
            chk($sformatf("t6_post_c_stall_%0d", i), 32'(c_stall), 32'(i == 4));
            tick();
        end
        drive_c(1'b0, 4'b0000, 12'h000, 32'h0);
        drive_x(1'b0, 4'b0000, 12'h000, 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
